// File: rtl/shared_match_requester.sv
// Shared-match requester: issues one match request per lazy slot of a job PE
// over the mesh, collects the tagged responses in any order, and presents the
// full batch of match lengths once every slot has answered.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 8
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 4
`endif
`ifndef MESH_X_SIZE_LOG2
`define MESH_X_SIZE_LOG2 2
`endif
`ifndef MESH_Y_SIZE_LOG2
`define MESH_Y_SIZE_LOG2 2
`endif
`ifndef SHARED_MATCH_PE_SLICE_SIZE_LOG2
`define SHARED_MATCH_PE_SLICE_SIZE_LOG2 10
`endif
`ifndef MESH_W
`define MESH_W 64
`endif

module shared_match_requester #(
  parameter int JOB_PE_IDX = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [`ADDR_WIDTH-1:0]                    req_head_addr,
  input  logic [`ADDR_WIDTH-1:0]                    req_history_addr,
  input  logic [`LAZY_LEN_LOG2-1:0]                 req_lazy_idx,
  output logic                                      to_mesh_valid,
  input  logic                                      to_mesh_ready,
  output logic [`MESH_X_SIZE_LOG2-1:0]              to_mesh_x_dst,
  output logic [`MESH_Y_SIZE_LOG2-1:0]              to_mesh_y_dst,
  output logic [`MESH_W-1:0]                        to_mesh_payload,
  input  logic                                      from_mesh_valid,
  output logic                                      from_mesh_ready,
  input  logic [`MESH_W-1:0]                        from_mesh_payload,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic [`LAZY_LEN*`MATCH_LEN_WIDTH-1:0]     result_match_len,
  output logic                                      protocol_err
);

  localparam int PE_W     = `NUM_JOB_PE_LOG2;
  localparam int IDX_W    = `LAZY_LEN_LOG2;
  localparam int LEN_W    = `MATCH_LEN_WIDTH;
  localparam int TAG_W    = PE_W + IDX_W;
  localparam int REQ_USED = TAG_W + 2 * `ADDR_WIDTH;
  localparam int RSP_USED = LEN_W + TAG_W;
  localparam logic [PE_W-1:0] JOB_PE = JOB_PE_IDX[PE_W-1:0];

  typedef enum logic {COLLECT, DONE} state_t;

  state_t                                state_q, state_d;
  logic [`LAZY_LEN-1:0]                  issued_q, issued_d;
  logic [`LAZY_LEN-1:0]                  resp_q, resp_d;
  logic [`LAZY_LEN-1:0][LEN_W-1:0]       len_q;

  logic                                  req_fire;
  logic                                  flit_taken;
  logic                                  result_fire;
  logic                                  resp_hit;
  logic                                  resp_bad;
  logic [PE_W-1:0]                       slice;
  logic [TAG_W-1:0]                      req_tag;
  logic [`MESH_W-1:0]                    req_payload;
  logic [LEN_W-1:0]                      resp_len;
  logic [IDX_W-1:0]                      resp_idx;
  logic [PE_W-1:0]                       resp_pe;
  logic                                  unused_resp_bits;

  // Request side: destination slice, tag and zero-extended flit payload
  assign slice       = req_history_addr[`SHARED_MATCH_PE_SLICE_SIZE_LOG2 +: PE_W];
  assign req_tag     = {JOB_PE, req_lazy_idx};
  assign req_payload = {{(`MESH_W-REQ_USED){1'b0}}, req_head_addr, req_history_addr, req_tag};

  // Response side: {match_len, tag} packed from the LSB upward
  assign resp_len         = from_mesh_payload[LEN_W-1:0];
  assign resp_idx         = from_mesh_payload[LEN_W +: IDX_W];
  assign resp_pe          = from_mesh_payload[LEN_W+IDX_W +: PE_W];
  assign unused_resp_bits = ^from_mesh_payload[`MESH_W-1:RSP_USED];

  assign from_mesh_ready  = 1'b1;
  assign result_match_len = len_q;
  assign flit_taken       = to_mesh_valid & to_mesh_ready;

  // Handshakes, response screening, mask updates and next state
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    resp_d       = resp_q;
    req_ready    = (state_q == COLLECT) & ~issued_q[req_lazy_idx] &
                   (~to_mesh_valid | to_mesh_ready);
    req_fire     = req_valid & req_ready;
    result_valid = (state_q == DONE);
    result_fire  = result_valid & result_ready;
    resp_hit     = from_mesh_valid & (resp_pe == JOB_PE) &
                   issued_q[resp_idx] & ~resp_q[resp_idx];
    resp_bad     = from_mesh_valid & ~resp_hit;
    if (req_fire) issued_d[req_lazy_idx] = 1'b1;
    if (resp_hit) resp_d[resp_idx] = 1'b1;
    if (result_fire) begin
      issued_d = '0;
      resp_d   = '0;
    end
    case (state_q)
      COLLECT: if (&resp_d) state_d = DONE;
      DONE:    if (result_fire) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM state and slot masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      issued_q <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      resp_q   <= resp_d;
    end
  end

  // Outgoing flit register: loads on accept, clears once the mesh takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_mesh_valid   <= 1'b0;
      to_mesh_x_dst   <= '0;
      to_mesh_y_dst   <= '0;
      to_mesh_payload <= '0;
    end else if (req_fire) begin
      to_mesh_valid   <= 1'b1;
      to_mesh_x_dst   <= slice[`MESH_X_SIZE_LOG2-1:0];
      to_mesh_y_dst   <= slice[`MESH_X_SIZE_LOG2 +: `MESH_Y_SIZE_LOG2];
      to_mesh_payload <= req_payload;
    end else if (flit_taken) begin
      to_mesh_valid   <= 1'b0;
      to_mesh_x_dst   <= '0;
      to_mesh_y_dst   <= '0;
      to_mesh_payload <= '0;
    end
  end

  // Per-slot match length storage, kept across batch hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else if (resp_hit) begin
      len_q[resp_idx] <= resp_len;
    end
  end

  // Sticky protocol error for any dropped response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (resp_bad) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_match_requester.sv
// Directed bench for shared_match_requester (JOB_PE_IDX = 3, LAZY_LEN = 4).
module tb_shared_match_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_head_addr;
  logic [15:0] req_history_addr;
  logic [1:0]  req_lazy_idx;
  logic        to_mesh_valid;
  logic        to_mesh_ready;
  logic [1:0]  to_mesh_x_dst;
  logic [1:0]  to_mesh_y_dst;
  logic [63:0] to_mesh_payload;
  logic        from_mesh_valid;
  logic        from_mesh_ready;
  logic [63:0] from_mesh_payload;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_match_len;
  logic        protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  shared_match_requester #(.JOB_PE_IDX(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_head_addr    (req_head_addr),
    .req_history_addr (req_history_addr),
    .req_lazy_idx     (req_lazy_idx),
    .to_mesh_valid    (to_mesh_valid),
    .to_mesh_ready    (to_mesh_ready),
    .to_mesh_x_dst    (to_mesh_x_dst),
    .to_mesh_y_dst    (to_mesh_y_dst),
    .to_mesh_payload  (to_mesh_payload),
    .from_mesh_valid  (from_mesh_valid),
    .from_mesh_ready  (from_mesh_ready),
    .from_mesh_payload(from_mesh_payload),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_match_len (result_match_len),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request flit layout from the LSB: tag {pe=3, idx}, history, head
  function automatic logic [63:0] exp_pl(input logic [15:0] head, input logic [15:0] hist,
                                         input logic [1:0] idx);
    return {26'b0, head, hist, 4'd3, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] idx, input logic [15:0] head, input logic [15:0] hist,
                       input logic [1:0] ex, input logic [1:0] ey);
    req_valid        = 1'b1;
    req_lazy_idx     = idx;
    req_head_addr    = head;
    req_history_addr = hist;
    #1;
    chk("req_ready_issue", {63'b0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    chk("flit_valid", {63'b0, to_mesh_valid}, 64'd1);
    chk("flit_x", {62'b0, to_mesh_x_dst}, {62'b0, ex});
    chk("flit_y", {62'b0, to_mesh_y_dst}, {62'b0, ey});
    chk("flit_payload", to_mesh_payload, exp_pl(head, hist, idx));
  endtask

  task automatic respond(input logic [3:0] pe, input logic [1:0] idx, input logic [7:0] len);
    from_mesh_valid   = 1'b1;
    from_mesh_payload = {50'b0, pe, idx, len};
    tick();
    from_mesh_valid   = 1'b0;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("result_released", {63'b0, result_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_head_addr = '0; req_history_addr = '0;
    req_lazy_idx = '0; to_mesh_ready = 1'b1; from_mesh_valid = 1'b0;
    from_mesh_payload = '0; result_ready = 1'b0;
    #1;
    chk("rst_flit_valid", {63'b0, to_mesh_valid}, 64'd0);
    chk("rst_result_valid", {63'b0, result_valid}, 64'd0);
    chk("rst_err", {63'b0, protocol_err}, 64'd0);
    chk("rst_lens", {32'b0, result_match_len}, 64'd0);
    chk("rst_payload", to_mesh_payload, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("from_mesh_ready", {63'b0, from_mesh_ready}, 64'd1);

    // In-order batch; first flit checked against a hand-packed constant too
    issue(2'd0, 16'h1234, 16'h2C00, 2'd3, 2'd2);
    chk("flit_payload_const", to_mesh_payload, 64'h0000_0004_8D0B_000C);
    issue(2'd1, 16'h0101, 16'h0400, 2'd1, 2'd0);
    issue(2'd2, 16'h0202, 16'h3800, 2'd2, 2'd3);
    issue(2'd3, 16'h0303, 16'h1000, 2'd0, 2'd1);
    tick();
    chk("flit_drained", {63'b0, to_mesh_valid}, 64'd0);
    respond(4'd3, 2'd0, 8'd5);
    respond(4'd3, 2'd1, 8'd6);
    respond(4'd3, 2'd2, 8'd7);
    chk("inorder_not_done", {63'b0, result_valid}, 64'd0);
    respond(4'd3, 2'd3, 8'd8);
    chk("inorder_done", {63'b0, result_valid}, 64'd1);
    chk("inorder_lens", {32'b0, result_match_len}, 64'h0807_0605);
    release_result();

    // Out-of-order responses 3,1,0,2 with a second address table
    issue(2'd0, 16'hAAAA, 16'hFFFF, 2'd3, 2'd3);
    issue(2'd1, 16'hBBBB, 16'h0000, 2'd0, 2'd0);
    issue(2'd2, 16'hCCCC, 16'h27FF, 2'd1, 2'd2);
    issue(2'd3, 16'hDDDD, 16'h1BFF, 2'd2, 2'd1);
    respond(4'd3, 2'd3, 8'h40);
    respond(4'd3, 2'd1, 8'h20);
    respond(4'd3, 2'd0, 8'h10);
    chk("ooo_not_done", {63'b0, result_valid}, 64'd0);
    respond(4'd3, 2'd2, 8'h30);
    chk("ooo_done", {63'b0, result_valid}, 64'd1);
    chk("ooo_lens", {32'b0, result_match_len}, 64'h4030_2010);
    release_result();

    // Backpressure: flit held for 5 cycles, next request waits, then both move
    to_mesh_ready = 1'b0;
    issue(2'd0, 16'h1111, 16'h2C00, 2'd3, 2'd2);
    req_valid = 1'b1; req_lazy_idx = 2'd1; req_head_addr = 16'h2222; req_history_addr = 16'h0400;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
      chk("bp_valid", {63'b0, to_mesh_valid}, 64'd1);
      chk("bp_payload", to_mesh_payload, exp_pl(16'h1111, 16'h2C00, 2'd0));
      chk("bp_x", {62'b0, to_mesh_x_dst}, 64'd3);
      tick();
    end
    to_mesh_ready = 1'b1;
    from_mesh_valid = 1'b1; from_mesh_payload = {50'b0, 4'd3, 2'd0, 8'h21};
    #1;
    chk("bp_req_ready_release", {63'b0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0; from_mesh_valid = 1'b0;
    chk("bp_next_valid", {63'b0, to_mesh_valid}, 64'd1);
    chk("bp_next_payload", to_mesh_payload, exp_pl(16'h2222, 16'h0400, 2'd1));
    issue(2'd2, 16'h3333, 16'h3800, 2'd2, 2'd3);
    issue(2'd3, 16'h4444, 16'h1000, 2'd0, 2'd1);
    respond(4'd3, 2'd1, 8'h22);
    respond(4'd3, 2'd2, 8'h23);
    respond(4'd3, 2'd3, 8'h24);
    chk("bp_done", {63'b0, result_valid}, 64'd1);
    chk("bp_lens", {32'b0, result_match_len}, 64'h2423_2221);
    req_valid = 1'b1; req_lazy_idx = 2'd0;
    #1;
    chk("done_blocks_req", {63'b0, req_ready}, 64'd0);
    req_valid = 1'b0;
    release_result();

    // Foreign tag dropped; slot 1 still accepts its genuine response
    issue(2'd0, 16'h0A0A, 16'h2C00, 2'd3, 2'd2);
    issue(2'd1, 16'h0B0B, 16'h0400, 2'd1, 2'd0);
    issue(2'd2, 16'h0C0C, 16'h3800, 2'd2, 2'd3);
    issue(2'd3, 16'h0D0D, 16'h1000, 2'd0, 2'd1);
    respond(4'd3, 2'd0, 8'h31);
    chk("foreign_err_before", {63'b0, protocol_err}, 64'd0);
    respond(4'd5, 2'd1, 8'h99);
    chk("foreign_err", {63'b0, protocol_err}, 64'd1);
    respond(4'd3, 2'd1, 8'h32);
    respond(4'd3, 2'd2, 8'h33);
    chk("foreign_not_done", {63'b0, result_valid}, 64'd0);
    respond(4'd3, 2'd3, 8'h34);
    chk("foreign_done", {63'b0, result_valid}, 64'd1);
    chk("foreign_lens", {32'b0, result_match_len}, 64'h3433_3231);
    chk("err_sticky", {63'b0, protocol_err}, 64'd1);
    release_result();

    // Mid-operation reset with 2 of 4 responses in and a flit stuck in flight
    issue(2'd0, 16'h0E0E, 16'h2C00, 2'd3, 2'd2);
    issue(2'd1, 16'h0F0F, 16'h0400, 2'd1, 2'd0);
    issue(2'd2, 16'h1010, 16'h3800, 2'd2, 2'd3);
    respond(4'd3, 2'd0, 8'h61);
    respond(4'd3, 2'd1, 8'h62);
    to_mesh_ready = 1'b0;
    issue(2'd3, 16'h1111, 16'h1000, 2'd0, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flit_valid", {63'b0, to_mesh_valid}, 64'd0);
    chk("mid_rst_payload", to_mesh_payload, 64'd0);
    chk("mid_rst_x", {62'b0, to_mesh_x_dst}, 64'd0);
    chk("mid_rst_result_valid", {63'b0, result_valid}, 64'd0);
    chk("mid_rst_err", {63'b0, protocol_err}, 64'd0);
    chk("mid_rst_lens", {32'b0, result_match_len}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    to_mesh_ready = 1'b1;
    tick();
    chk("post_rst_flit_valid", {63'b0, to_mesh_valid}, 64'd0);
    issue(2'd0, 16'h1212, 16'h2C00, 2'd3, 2'd2);
    issue(2'd1, 16'h1313, 16'h0400, 2'd1, 2'd0);
    issue(2'd2, 16'h1414, 16'h3800, 2'd2, 2'd3);
    issue(2'd3, 16'h1515, 16'h1000, 2'd0, 2'd1);
    respond(4'd3, 2'd0, 8'h41);
    respond(4'd3, 2'd1, 8'h42);
    respond(4'd3, 2'd2, 8'h43);
    chk("post_rst_not_done", {63'b0, result_valid}, 64'd0);
    respond(4'd3, 2'd3, 8'h44);
    chk("post_rst_done", {63'b0, result_valid}, 64'd1);
    chk("post_rst_lens", {32'b0, result_match_len}, 64'h4443_4241);
    release_result();

    // Duplicate slot: request blocked, second response dropped and flagged
    issue(2'd0, 16'h1616, 16'h2C00, 2'd3, 2'd2);
    issue(2'd1, 16'h1717, 16'h0400, 2'd1, 2'd0);
    issue(2'd2, 16'h1818, 16'h3800, 2'd2, 2'd3);
    req_valid = 1'b1; req_lazy_idx = 2'd2;
    #1;
    chk("dup_req_ready", {63'b0, req_ready}, 64'd0);
    req_valid = 1'b0;
    respond(4'd3, 2'd2, 8'h52);
    chk("dup_err_before", {63'b0, protocol_err}, 64'd0);
    respond(4'd3, 2'd2, 8'h77);
    chk("dup_err", {63'b0, protocol_err}, 64'd1);
    issue(2'd3, 16'h1919, 16'h1000, 2'd0, 2'd1);
    respond(4'd3, 2'd0, 8'h50);
    respond(4'd3, 2'd1, 8'h51);
    respond(4'd3, 2'd3, 8'h53);
    chk("dup_done", {63'b0, result_valid}, 64'd1);
    chk("dup_lens", {32'b0, result_match_len}, 64'h5352_5150);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shared_match_requester.md
SHARED_MATCH_REQUESTER -- requirements
Module: shared_match_requester

Interface
REQ-001 SHALL have parameter JOB_PE_IDX, default 0: index of the owning job PE, placed in the upper field of every outgoing tag.
REQ-002 SHALL have ports `clk` (input, 1): the single clock; `rst_n` (input, 1): asynchronous active-low reset.
REQ-003 SHALL have request-side ports from the job PE:
- `req_valid` (in, 1) and `req_ready` (out, 1): handshake.
- `req_head_addr` (in, `ADDR_WIDTH).
- `req_history_addr` (in, `ADDR_WIDTH).
- `req_lazy_idx` (in, `LAZY_LEN_LOG2).
REQ-004 SHALL have mesh-transmit ports:
- `to_mesh_valid` (out, 1) and `to_mesh_ready` (in, 1).
- `to_mesh_x_dst` (out, `MESH_X_SIZE_LOG2).
- `to_mesh_y_dst` (out, `MESH_Y_SIZE_LOG2).
- `to_mesh_payload` (out, `MESH_W).
REQ-005 SHALL have mesh-receive ports `from_mesh_valid` (in, 1), `from_mesh_ready` (out, 1) and `from_mesh_payload` (in, `MESH_W).
REQ-006 SHALL have result ports:
- `result_valid` (out, 1) and `result_ready` (in, 1).
- `result_match_len` (out, `LAZY_LEN*`MATCH_LEN_WIDTH): slot i occupies bits [i*`MATCH_LEN_WIDTH +: `MATCH_LEN_WIDTH].
REQ-007 SHALL have `protocol_err` (out, 1): sticky error flag.

Function
REQ-008 SHALL compute the destination slice as req_history_addr[`SHARED_MATCH_PE_SLICE_SIZE_LOG2 +: `NUM_JOB_PE_LOG2].
REQ-009 SHALL map the slice to the mesh as x_dst = slice[`MESH_X_SIZE_LOG2-1:0] and y_dst = slice[`MESH_X_SIZE_LOG2 +: `MESH_Y_SIZE_LOG2].
REQ-010 SHALL form tag = {JOB_PE_IDX[`NUM_JOB_PE_LOG2-1:0], req_lazy_idx}.
REQ-011 SHALL pack the request payload LSB-first as {tag, history_addr, head_addr}, zero-extended to `MESH_W.
REQ-012 SHALL hold the outgoing flit in one output register:
- Latency from request accept to to_mesh_valid is 1 cycle.
- The register loads on a request accept.
- The register clears when the flit is accepted (to_mesh_valid & to_mesh_ready) and no new request is accepted in the same cycle.
REQ-013 SHALL drive req_ready = (state==COLLECT) & ~issued_mask[req_lazy_idx] & (~to_mesh_valid | to_mesh_ready).
REQ-014 SHALL hold to_mesh_x_dst, to_mesh_y_dst and to_mesh_payload stable while to_mesh_valid is high and to_mesh_ready is low.
REQ-015 SHALL keep issued_mask and resp_mask, each `LAZY_LEN bits:
- A request accept sets issued_mask[lazy_idx].
- A valid response sets resp_mask[tag lazy field].
- The response's match_len is stored in that slot's register.
REQ-016 SHALL decode the response payload LSB-first as {match_len[`MATCH_LEN_WIDTH], tag}.
REQ-017 SHALL tie from_mesh_ready to 1 and drop any response that meets any of these conditions, setting protocol_err the next cycle:
- its job-PE field is not JOB_PE_IDX;
- issued_mask is clear for its slot;
- resp_mask is already set for its slot.
REQ-018 SHALL implement the FSM with two states: COLLECT (the reset state) and DONE.
REQ-019 SHALL move COLLECT→DONE in the cycle after resp_mask becomes all ones.
- In DONE, result_valid=1 and result_match_len holds the stored lengths.
REQ-020 SHALL, on result_valid & result_ready in DONE:
- clear both masks;
- return to COLLECT the next cycle;
- leave the length registers unchanged.
REQ-021 SHALL accept requests and responses in the same cycle, including a response for a slot issued in an earlier cycle.
REQ-022 SHALL NOT accept new requests in DONE, so that a batch never mixes with the next batch.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set:
- state=COLLECT;
- both masks to 0;
- to_mesh_valid, result_valid and protocol_err to 0;
- the length registers and payload register to 0.
REQ-024 SHALL discard in-flight flits and partial batches on a mid-operation reset, with no output asserted until after reset deasserts.
REQ-025 SHALL keep protocol_err set until reset.

Verification
REQ-026 SHALL pass these directed scenarios:
- In-order batch: with LAZY_LEN=4 and to_mesh_ready=1, issue idx 0..3, then return lens 5,6,7,8 in order → result_valid one cycle after the last response, with result_match_len slots = 5,6,7,8.
- Out-of-order responses and x/y mapping: responses arrive in order 3,1,0,2 → lens land in the correct slots, and each x_dst/y_dst matches the history_addr slice bits.
- Backpressure: hold to_mesh_ready=0 for 5 cycles → payload stays stable, req_ready=0, no request is lost, and the flit transfers on the first ready cycle.
- Duplicate slot: with issued_mask[2]=1, present req_lazy_idx=2 → req_ready=0. A duplicate response for slot 2 → dropped, protocol_err=1 the next cycle.
- Foreign tag: a response whose job-PE field ≠ JOB_PE_IDX → dropped, resp_mask unchanged, protocol_err=1.
- Mid-operation reset: assert reset with 2 of 4 responses received → all outputs 0. A new batch after reset completes normally.
